// File: rtl/otter_mem_pkg.sv
// Shared types and helpers for the OTTER memory: access sizes, port-2 FSM states,
// load-data source select and the alignment rule.
package otter_mem_pkg;

  typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2, ILL = 2'd3} mem_size_e;
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} mem_state_e;
  typedef enum logic [1:0] {RAM = 2'd0, IO = 2'd1, ZERO = 2'd2} dout_sel_e;

  // Halfwords may straddle bytes 1-2 but not leave the word; words must be aligned.
  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] off);
    logic bad;
    case (size)
      BYTE:    bad = 1'b0;
      HALF:    bad = (off == 2'd3);
      WORD:    bad = (off != 2'd0);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/otter_mem_sizer.sv
// Combinational load formatter: picks byte/half/word at the byte offset and
// zero- or sign-extends it to 32 bits. Shared by the RAM and IO read paths.
module otter_mem_sizer
  import otter_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  mem_size_e   size_i,
  input  logic        uns_i,
  input  logic [1:0]  off_i,
  output logic [31:0] data_o
);

  logic [31:0] sh;

  always_comb begin
    sh = word_i >> {off_i, 3'b000};
    case (size_i)
      BYTE:    data_o = uns_i ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      HALF:    data_o = uns_i ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      WORD:    data_o = word_i;
      default: data_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/otter_mem_v2.sv
// OTTER RV32I memory: 1-cycle dual-read/single-write RAM plus an MMIO region reached
// through a req/ack handshake; MEM_BUSY stalls the CPU while an IO access is pending.
module otter_mem_v2
  import otter_mem_pkg::*;
#(
  parameter int          ADDR_W     = 16,
  parameter logic [31:0] IO_BASE    = 32'h0001_0000,
  parameter int          IO_TIMEOUT = 16,
  parameter              INIT_FILE  = "otter_mem.mem"
) (
  input  logic              MEM_CLK,
  input  logic              MEM_RST,
  input  logic              MEM_RDEN1,
  input  logic              MEM_RDEN2,
  input  logic              MEM_WE2,
  input  logic [ADDR_W-3:0] MEM_ADDR1,
  input  logic [31:0]       MEM_ADDR2,
  input  logic [31:0]       MEM_DIN2,
  input  logic [1:0]        MEM_SIZE,
  input  logic              MEM_SIGN,
  input  logic [31:0]       IO_IN,
  input  logic              IO_ACK,
  output logic              IO_RD,
  output logic              IO_WR,
  output logic [31:0]       IO_ADDR,
  output logic [31:0]       IO_DOUT,
  output logic [31:0]       MEM_DOUT1,
  output logic [31:0]       MEM_DOUT2,
  output logic              MEM_BUSY,
  output logic              MEM_ERR
);

  localparam int          DEPTH   = 2 ** (ADDR_W - 2);
  localparam logic [31:0] TO_LAST = 32'(IO_TIMEOUT - 1);

  logic [31:0] mem [DEPTH];

  mem_state_e  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        io_rd_q, io_rd_d, io_wr_q, io_wr_d;
  logic [31:0] io_addr_q, io_addr_d, io_dout_q, io_dout_d, io_buf_q, io_buf_d;
  logic [31:0] dout1_q, dout1_d, ram_rd_q, ram_rd_d;
  dout_sel_e   sel_q, sel_d;
  mem_size_e   size_q, size_d, io_size_q, io_size_d;
  logic        sign_q, sign_d, io_sign_q, io_sign_d;
  logic [1:0]  off_q, off_d, io_off_q, io_off_d;
  logic        err_q, err_d;

  logic [1:0]        off;
  mem_size_e         size_in;
  logic              acc, mis, io_hit, timeout, ram_we;
  logic [ADDR_W-3:0] widx;
  logic [31:0]       wdat, word_sel;
  logic [3:0]        be;

  always_comb begin
    off     = MEM_ADDR2[1:0];
    size_in = mem_size_e'(MEM_SIZE);
    widx    = MEM_ADDR2[ADDR_W-1:2];
    acc     = MEM_RDEN2 | MEM_WE2;
    mis     = is_misaligned(size_in, off);
    io_hit  = (MEM_ADDR2 >= IO_BASE);
    timeout = (state_q == WAIT) && !IO_ACK && (IO_TIMEOUT != 0) && (cnt_q == TO_LAST);
    wdat    = MEM_DIN2 << {off, 3'b000};
    case (size_in)
      BYTE:    be = 4'b0001 << off;
      HALF:    be = 4'b0011 << off;
      WORD:    be = 4'b1111;
      default: be = 4'b0000;
    endcase

    state_d   = state_q;
    cnt_d     = cnt_q;
    io_rd_d   = io_rd_q;
    io_wr_d   = io_wr_q;
    io_addr_d = io_addr_q;
    io_dout_d = io_dout_q;
    io_buf_d  = io_buf_q;
    ram_rd_d  = ram_rd_q;
    sel_d     = sel_q;
    size_d    = size_q;
    sign_d    = sign_q;
    off_d     = off_q;
    io_size_d = io_size_q;
    io_sign_d = io_sign_q;
    io_off_d  = io_off_q;
    err_d     = 1'b0;
    ram_we    = 1'b0;
    MEM_BUSY  = 1'b0;
    dout1_d   = MEM_RDEN1 ? mem[MEM_ADDR1] : dout1_q;

    case (state_q)
      IDLE: begin
        if (acc && mis) begin
          err_d = 1'b1;
          if (MEM_RDEN2) sel_d = ZERO;
        end else if (acc && io_hit) begin
          MEM_BUSY  = 1'b1;
          state_d   = WAIT;
          cnt_d     = 32'd0;
          io_rd_d   = MEM_RDEN2;
          io_wr_d   = MEM_WE2;
          io_addr_d = MEM_ADDR2;
          io_dout_d = MEM_DIN2;
          io_size_d = size_in;
          io_sign_d = MEM_SIGN;
          io_off_d  = off;
        end else if (acc) begin
          ram_we = MEM_WE2;
          if (MEM_RDEN2) begin
            // Array is read before this edge's write lands: read-first on both ports.
            ram_rd_d = mem[widx];
            sel_d    = RAM;
            size_d   = size_in;
            sign_d   = MEM_SIGN;
            off_d    = off;
          end
        end
      end
      WAIT: begin
        MEM_BUSY = !IO_ACK && !timeout;
        if (IO_ACK) begin
          io_buf_d = IO_IN;
          io_rd_d  = 1'b0;
          io_wr_d  = 1'b0;
          state_d  = IDLE;
          if (io_rd_q) begin
            sel_d  = IO;
            size_d = io_size_q;
            sign_d = io_sign_q;
            off_d  = io_off_q;
          end
        end else if (timeout) begin
          io_rd_d = 1'b0;
          io_wr_d = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
          if (io_rd_q) sel_d = ZERO;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (MEM_RST) begin
      MEM_BUSY = 1'b0;
      ram_we   = 1'b0;
    end

    case (sel_q)
      RAM:     word_sel = ram_rd_q;
      IO:      word_sel = io_buf_q;
      default: word_sel = 32'd0;
    endcase
  end

  always_ff @(posedge MEM_CLK) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wdat[8*i +: 8];
      end
    end
  end

  always_ff @(posedge MEM_CLK or posedge MEM_RST) begin
    if (MEM_RST) begin
      state_q   <= IDLE;
      cnt_q     <= 32'd0;
      io_rd_q   <= 1'b0;
      io_wr_q   <= 1'b0;
      io_addr_q <= 32'd0;
      io_dout_q <= 32'd0;
      io_buf_q  <= 32'd0;
      dout1_q   <= 32'd0;
      ram_rd_q  <= 32'd0;
      sel_q     <= ZERO;
      size_q    <= WORD;
      sign_q    <= 1'b0;
      off_q     <= 2'd0;
      io_size_q <= WORD;
      io_sign_q <= 1'b0;
      io_off_q  <= 2'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      io_rd_q   <= io_rd_d;
      io_wr_q   <= io_wr_d;
      io_addr_q <= io_addr_d;
      io_dout_q <= io_dout_d;
      io_buf_q  <= io_buf_d;
      dout1_q   <= dout1_d;
      ram_rd_q  <= ram_rd_d;
      sel_q     <= sel_d;
      size_q    <= size_d;
      sign_q    <= sign_d;
      off_q     <= off_d;
      io_size_q <= io_size_d;
      io_sign_q <= io_sign_d;
      io_off_q  <= io_off_d;
      err_q     <= err_d;
    end
  end

  otter_mem_sizer u_sizer (
    .word_i (word_sel),
    .size_i (size_q),
    .uns_i  (sign_q),
    .off_i  (off_q),
    .data_o (MEM_DOUT2)
  );

  assign IO_RD     = io_rd_q;
  assign IO_WR     = io_wr_q;
  assign IO_ADDR   = io_addr_q;
  assign IO_DOUT   = io_dout_q;
  assign MEM_DOUT1 = dout1_q;
  assign MEM_ERR   = err_q;

endmodule

// File: tb/tb_otter_mem_v2.sv
// Bench for otter_mem_v2: directed vector table, randomized RAM traffic against a
// byte-array model, and hand-written IO handshake / timeout / reset sequences.
module tb_otter_mem_v2;

  localparam int TO = 16;

  logic        MEM_CLK, MEM_RST, MEM_RDEN1, MEM_RDEN2, MEM_WE2, MEM_SIGN, IO_ACK;
  logic [13:0] MEM_ADDR1;
  logic [31:0] MEM_ADDR2, MEM_DIN2, IO_IN;
  logic [1:0]  MEM_SIZE;
  logic        IO_RD, IO_WR, MEM_BUSY, MEM_ERR;
  logic [31:0] IO_ADDR, IO_DOUT, MEM_DOUT1, MEM_DOUT2;

  otter_mem_v2 #(.ADDR_W(16), .IO_BASE(32'h0001_0000), .IO_TIMEOUT(TO), .INIT_FILE("")) dut (
    .MEM_CLK(MEM_CLK), .MEM_RST(MEM_RST), .MEM_RDEN1(MEM_RDEN1), .MEM_RDEN2(MEM_RDEN2),
    .MEM_WE2(MEM_WE2), .MEM_ADDR1(MEM_ADDR1), .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2),
    .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN), .IO_IN(IO_IN), .IO_ACK(IO_ACK),
    .IO_RD(IO_RD), .IO_WR(IO_WR), .IO_ADDR(IO_ADDR), .IO_DOUT(IO_DOUT),
    .MEM_DOUT1(MEM_DOUT1), .MEM_DOUT2(MEM_DOUT2), .MEM_BUSY(MEM_BUSY), .MEM_ERR(MEM_ERR)
  );

  initial MEM_CLK = 1'b0;
  always #5 MEM_CLK = ~MEM_CLK;

  int checks = 0;
  int failures = 0;
  logic [7:0]  mdl [0:1023];
  logic        p1_on;
  logic [31:0] p1_exp;

  typedef struct {
    logic rd; logic we; logic [31:0] addr; logic [31:0] din;
    logic [1:0] sz; logic uns; logic [31:0] exp_d; logic exp_e;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  function automatic bit mis_f(input int sz, input int off);
    return (sz == 3) || (sz == 1 && off == 3) || (sz == 2 && off != 0);
  endfunction

  function automatic logic [31:0] mload(input int a, input int sz, input bit uns);
    int v;
    if (mis_f(sz, a % 4)) return 32'd0;
    if (sz == 0) begin
      v = mdl[a];
      if (!uns && v >= 128) v -= 256;
    end else if (sz == 1) begin
      v = mdl[a] + 256 * mdl[a+1];
      if (!uns && v >= 32768) v -= 65536;
    end else begin
      v = mdl[a] + 256 * mdl[a+1] + 65536 * mdl[a+2] + 16777216 * mdl[a+3];
    end
    return 32'(v);
  endfunction

  task automatic mstore(input int a, input int sz, input logic [31:0] din);
    for (int i = 0; i < (1 << sz); i++) mdl[a+i] = din[8*i +: 8];
  endtask

  task automatic p1_pre();
    int wa;
    if (p1_on) begin
      wa = $urandom_range(128, 255);
      MEM_RDEN1 = 1'b1;
      MEM_ADDR1 = 14'(wa);
      p1_exp = mload(wa * 4, 2, 1'b1);
    end else begin
      MEM_RDEN1 = 1'b0;
    end
  endtask

  task automatic p1_post();
    if (p1_on) chk("p1_fetch", MEM_DOUT1, p1_exp);
  endtask

  task automatic ram_op(input logic rd, input logic we, input logic [31:0] addr,
                        input logic [31:0] din, input logic [1:0] sz, input logic uns,
                        output logic [31:0] dout, output logic err);
    MEM_RDEN2 = rd; MEM_WE2 = we; MEM_ADDR2 = addr; MEM_DIN2 = din;
    MEM_SIZE = sz; MEM_SIGN = uns;
    p1_pre();
    @(posedge MEM_CLK); #1;
    MEM_RDEN2 = 1'b0; MEM_WE2 = 1'b0;
    p1_post();
    dout = MEM_DOUT2;
    err = MEM_ERR;
  endtask

  // Called at posedge+1; returns at posedge+1 after the completing edge.
  task automatic io_txn(input logic rd, input logic we, input logic [31:0] addr,
                        input logic [31:0] din, input logic [1:0] sz, input logic uns,
                        input int ack_at, input logic [31:0] ack_dat,
                        output int busy_n, output int str_n, output int str_all, output int done_at);
    logic b;
    MEM_RDEN2 = rd; MEM_WE2 = we; MEM_ADDR2 = addr; MEM_DIN2 = din;
    MEM_SIZE = sz; MEM_SIGN = uns;
    busy_n = 0; str_n = 0; str_all = 0; done_at = -1;
    for (int c = 0; c < 40; c++) begin
      IO_IN = ack_dat;
      IO_ACK = (c == ack_at);
      p1_pre();
      #1;
      b = MEM_BUSY;
      if (b) busy_n++;
      if (IO_RD | IO_WR) str_all++;
      if ((IO_RD | IO_WR) && !IO_ACK) str_n++;
      @(posedge MEM_CLK); #1;
      IO_ACK = 1'b0;
      p1_post();
      if (!b) begin
        done_at = c;
        break;
      end
    end
    MEM_RDEN2 = 1'b0; MEM_WE2 = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, exp_d2;
    logic e;
    int b, s, sa, dn, a, sz, kind;
    logic rd, we, uns;
    logic [31:0] din;

    p1_on = 1'b0;
    MEM_RST = 1'b1; MEM_RDEN1 = 0; MEM_RDEN2 = 0; MEM_WE2 = 0; MEM_ADDR1 = '0;
    MEM_ADDR2 = '0; MEM_DIN2 = '0; MEM_SIZE = 2'd2; MEM_SIGN = 0; IO_IN = '0; IO_ACK = 0;
    for (int i = 0; i < 1024; i++) mdl[i] = 8'h00;
    #1;
    chk("rst_dout1", MEM_DOUT1, 0);
    chk("rst_dout2", MEM_DOUT2, 0);
    chk("rst_io_rd", {31'd0, IO_RD}, 0);
    chk("rst_io_wr", {31'd0, IO_WR}, 0);
    chk("rst_io_addr", IO_ADDR, 0);
    chk("rst_io_dout", IO_DOUT, 0);
    chk("rst_err", {31'd0, MEM_ERR}, 0);
    chk("rst_busy", {31'd0, MEM_BUSY}, 0);
    @(posedge MEM_CLK); @(posedge MEM_CLK); #1;
    MEM_RST = 1'b0;

    // Fill the random region so every later read has a defined model value.
    for (int w = 128; w < 256; w++) begin
      din = $urandom;
      ram_op(0, 1, 32'(w * 4), din, 2'd2, 0, d, e);
      mstore(w * 4, 2, din);
    end
    p1_on = 1'b1;

    tbl.push_back('{0, 1, 32'h100, 32'h12345678, 2, 0, 32'h0, 0});
    tbl.push_back('{1, 0, 32'h101, 32'h0, 0, 1, 32'h00000056, 0});
    tbl.push_back('{1, 0, 32'h102, 32'h0, 1, 0, 32'h00001234, 0});
    tbl.push_back('{1, 0, 32'h103, 32'h0, 0, 0, 32'h00000012, 0});
    tbl.push_back('{0, 1, 32'h103, 32'hFFFF, 1, 0, 32'h00000012, 1});
    tbl.push_back('{1, 0, 32'h100, 32'h0, 2, 0, 32'h12345678, 0});
    tbl.push_back('{1, 0, 32'h102, 32'h0, 2, 0, 32'h0, 1});
    tbl.push_back('{0, 0, 32'h100, 32'h0, 2, 0, 32'h0, 0});
    tbl.push_back('{0, 1, 32'h101, 32'h80, 0, 0, 32'h0, 0});
    tbl.push_back('{1, 0, 32'h101, 32'h0, 0, 0, 32'hFFFFFF80, 0});
    tbl.push_back('{1, 0, 32'h100, 32'h0, 1, 1, 32'h00008078, 0});
    tbl.push_back('{1, 0, 32'h100, 32'h0, 3, 0, 32'h0, 1});
    tbl.push_back('{0, 1, 32'h101, 32'hBEEF, 1, 0, 32'h0, 0});
    tbl.push_back('{1, 0, 32'h100, 32'h0, 2, 0, 32'h12BEEF78, 0});
    tbl.push_back('{1, 1, 32'h100, 32'hDEADBEEF, 2, 0, 32'h12BEEF78, 0});
    tbl.push_back('{1, 0, 32'h100, 32'h0, 2, 0, 32'hDEADBEEF, 0});
    for (int i = 0; i < tbl.size(); i++) begin
      ram_op(tbl[i].rd, tbl[i].we, tbl[i].addr, tbl[i].din, tbl[i].sz, tbl[i].uns, d, e);
      chk($sformatf("vec%0d_dout", i), d, tbl[i].exp_d);
      chk($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, tbl[i].exp_e});
    end

    exp_d2 = 32'hDEADBEEF;
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      a = $urandom_range(512, 1023);
      sz = $urandom_range(0, 3);
      uns = 1'($urandom_range(0, 1));
      din = $urandom;
      rd = (kind >= 1 && kind <= 5) || kind == 9;
      we = kind >= 6;
      if (kind == 0) begin
        a = a & ~3;
        sz = 2;
      end
      if (rd) exp_d2 = mload(a, sz, uns);
      ram_op(rd, we, 32'(a), din, 2'(sz), uns, d, e);
      chk("rand_dout", d, exp_d2);
      chk("rand_err", {31'd0, e}, {31'd0, (rd | we) && mis_f(sz, a % 4)});
      if (we && !mis_f(sz, a % 4)) mstore(a, sz, din);
    end

    io_txn(1, 0, 32'h11000, 0, 2'd2, 0, 4, 32'hCAFEF00D, b, s, sa, dn);
    chk("io_rd_busy_cycles", b, 4);
    chk("io_rd_strobe_cycles", s, 3);
    chk("io_rd_done", dn, 4);
    chk("io_rd_data", MEM_DOUT2, 32'hCAFEF00D);
    chk("io_rd_addr", IO_ADDR, 32'h11000);
    chk("io_rd_drop", {31'd0, IO_RD}, 0);
    chk("io_rd_err", {31'd0, MEM_ERR}, 0);

    io_txn(0, 1, 32'h11004, 32'hA5, 2'd2, 0, -1, 0, b, s, sa, dn);
    chk("io_to_busy_cycles", b, TO);
    chk("io_to_strobe_cycles", s, TO);
    chk("io_to_done", dn, TO);
    chk("io_to_err", {31'd0, MEM_ERR}, 1);
    chk("io_to_wr_drop", {31'd0, IO_WR}, 0);
    chk("io_to_dout", IO_DOUT, 32'hA5);
    p1_pre();
    @(posedge MEM_CLK); #1;
    p1_post();
    chk("io_to_err_pulse", {31'd0, MEM_ERR}, 0);

    IO_ACK = 1'b1; IO_IN = 32'h55AA55AA;
    #1;
    chk("stray_ack_busy", {31'd0, MEM_BUSY}, 0);
    @(posedge MEM_CLK); #1;
    IO_ACK = 1'b0;
    chk("stray_ack_rd", {31'd0, IO_RD}, 0);
    chk("stray_ack_wr", {31'd0, IO_WR}, 0);
    chk("stray_ack_dout", MEM_DOUT2, 32'hCAFEF00D);
    chk("stray_ack_err", {31'd0, MEM_ERR}, 0);

    io_txn(1, 0, 32'h11010, 0, 2'd2, 0, -1, 32'h77777777, b, s, sa, dn);
    chk("io_rd_to_done", dn, TO);
    chk("io_rd_to_dout", MEM_DOUT2, 0);
    chk("io_rd_to_err", {31'd0, MEM_ERR}, 1);

    io_txn(1, 0, 32'h11008, 0, 2'd2, 0, 1, 32'h01234567, b, s, sa, dn);
    chk("b2b1_busy", b, 1);
    chk("b2b1_strobes", sa, 1);
    chk("b2b1_data", MEM_DOUT2, 32'h01234567);
    chk("b2b1_drop", {31'd0, IO_RD}, 0);
    io_txn(1, 0, 32'h11002, 0, 2'd1, 0, 1, 32'hCAFEF00D, b, s, sa, dn);
    chk("b2b2_busy", b, 1);
    chk("b2b2_strobes", sa, 1);
    chk("b2b2_addr", IO_ADDR, 32'h11002);
    chk("b2b2_data", MEM_DOUT2, 32'hFFFFCAFE);
    chk("b2b2_drop", {31'd0, IO_RD}, 0);

    p1_on = 1'b0;
    MEM_RDEN1 = 1'b0;
    MEM_RDEN2 = 1'b1; MEM_WE2 = 1'b0; MEM_ADDR2 = 32'h11000; MEM_SIZE = 2'd2; MEM_SIGN = 0;
    @(posedge MEM_CLK); #1;
    chk("rstw_rd_up", {31'd0, IO_RD}, 1);
    @(posedge MEM_CLK); #3;
    MEM_RST = 1'b1;
    #1;
    chk("rstw_rd_async", {31'd0, IO_RD}, 0);
    chk("rstw_busy", {31'd0, MEM_BUSY}, 0);
    chk("rstw_dout2", MEM_DOUT2, 0);
    MEM_RDEN2 = 1'b0;
    @(posedge MEM_CLK); #1;
    MEM_RST = 1'b0;
    @(posedge MEM_CLK); #1;
    chk("rstw_no_relaunch", {31'd0, IO_RD}, 0);
    ram_op(1, 0, 32'h100, 0, 2'd2, 0, d, e);
    chk("rstw_ram_kept", d, 32'hDEADBEEF);
    chk("rstw_ram_err", {31'd0, e}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
